// File: rtl/lake_pkg.sv
// Shared defaults and typedefs for the lake de-aggregation buffer.
// Occupancy counts buffered wide words; lane_cnt_t sizes a lane count.
package lake_pkg;

    localparam int DEFAULT_DATA_WIDTH  = 16;
    localparam int DEFAULT_FETCH_WIDTH = 4;

    typedef logic [1:0] occ_t;
    typedef logic [$clog2(DEFAULT_FETCH_WIDTH):0] lane_cnt_t;

    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/lake_deagg_buffer.sv
// Two-entry ping-pong buffer that splits wide words into narrow lanes,
// emitting only the first lane_count lanes of each word.
module lake_deagg_buffer
    import lake_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int FETCH_WIDTH = DEFAULT_FETCH_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FETCH_WIDTH*DATA_WIDTH-1:0] i_wide_data,
    input  logic                              i_wide_valid,
    output logic                              o_wide_ready,
    input  logic [$clog2(FETCH_WIDTH):0]      i_lane_count,
    output logic [DATA_WIDTH-1:0]             o_data_out,
    output logic                              o_data_valid,
    input  logic                              i_data_ready,
    output logic                              o_last
);

    localparam int LW = $clog2(FETCH_WIDTH);
    localparam int CW = LW + 1;
    localparam int WW = FETCH_WIDTH * DATA_WIDTH;

    logic [WW-1:0] r_data [2];
    logic [CW-1:0] r_cnt  [2];
    logic          r_wr_ptr;
    logic          r_rd_ptr;
    occ_t          r_occ;
    logic [LW-1:0] r_lane;

    logic          w_push;
    logic          w_pop;
    logic          w_pop_last;
    logic [CW-1:0] w_eff_cnt;
    logic [CW-1:0] w_cnt_m1;
    logic [WW-1:0] w_word;

    assign o_wide_ready = (r_occ < OCC_FULL);
    assign o_data_valid = (r_occ != OCC_EMPTY);

    assign w_word     = r_data[r_rd_ptr];
    assign w_cnt_m1   = r_cnt[r_rd_ptr] - CW'(1);
    assign o_data_out = w_word[int'(r_lane)*DATA_WIDTH +: DATA_WIDTH];
    assign o_last     = o_data_valid && ({1'b0, r_lane} == w_cnt_m1);

    // Zero or overrange counts mean "emit the whole word".
    assign w_eff_cnt = (i_lane_count == '0 ||
                        i_lane_count > CW'(FETCH_WIDTH))
                     ? CW'(FETCH_WIDTH) : i_lane_count;

    assign w_push     = i_wide_valid && o_wide_ready && !rst;
    assign w_pop      = o_data_valid && i_data_ready;
    assign w_pop_last = w_pop && o_last;

    // Storage is intentionally left unreset; occupancy gates its use.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wr_ptr] <= i_wide_data;
            r_cnt[r_wr_ptr]  <= w_eff_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_occ    <= OCC_EMPTY;
            r_lane   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                if (o_last) begin
                    r_lane   <= '0;
                    r_rd_ptr <= ~r_rd_ptr;
                end else begin
                    r_lane <= r_lane + LW'(1);
                end
            end
            unique case ({w_push, w_pop_last})
                2'b10:   r_occ <= r_occ + occ_t'(1);
                2'b01:   r_occ <= r_occ - occ_t'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

endmodule

// File: tb/tb_lake_deagg_buffer.sv
// Directed vector table plus scoreboard sequences for lake_deagg_buffer.
module tb_lake_deagg_buffer;
    import lake_pkg::*;

    logic            clk;
    logic            rst;
    logic [63:0]     i_wide_data;
    logic            i_wide_valid;
    logic            o_wide_ready;
    lane_cnt_t       i_lane_count;
    logic [15:0]     o_data_out;
    logic            o_data_valid;
    logic            i_data_ready;
    logic            o_last;

    lake_deagg_buffer #(.DATA_WIDTH(16), .FETCH_WIDTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wide_data (i_wide_data),
        .i_wide_valid(i_wide_valid),
        .o_wide_ready(o_wide_ready),
        .i_lane_count(i_lane_count),
        .o_data_out  (o_data_out),
        .o_data_valid(o_data_valid),
        .i_data_ready(i_data_ready),
        .o_last      (o_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wv;
        logic [63:0] wd;
        logic [2:0]  lc;
        logic        dr;
        logic        chk;
        logic        ev;
        logic [15:0] ed;
        logic        el;
        logic        ewr;
    } vec_t;

    typedef struct {
        logic [15:0] d;
        logic        l;
    } lane_t;

    vec_t  vt[$];
    lane_t q[$];
    int    n_vec;
    int    n_err;

    function automatic vec_t mk(
        input logic rs, input logic wv, input logic [63:0] wd,
        input logic [2:0] lc, input logic dr, input logic chk,
        input logic ev, input logic [15:0] ed, input logic el,
        input logic ewr);
        vec_t v;
        v.rst = rs; v.wv = wv; v.wd = wd; v.lc = lc; v.dr = dr;
        v.chk = chk; v.ev = ev; v.ed = ed; v.el = el; v.ewr = ewr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic idle();
        i_wide_valid = 1'b0;
        i_wide_data  = '0;
        i_lane_count = '0;
        i_data_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic model_push(input logic [63:0] wd, input logic [2:0] lc);
        int eff;
        lane_t e;
        eff = (lc == 0 || lc > 4) ? 4 : int'(lc);
        for (int k = 0; k < eff; k++) begin
            e.d = wd[k*16 +: 16];
            e.l = (k == eff - 1);
            q.push_back(e);
        end
    endtask

    // Scoreboard run; rnd=0 gives continuous valid/ready with count 4.
    task automatic run_sb(input int nwords, input bit rnd, input int budget);
        int    sent;
        int    first;
        int    lastc;
        int    c;
        lane_t e;
        sent  = 0;
        first = -1;
        lastc = -1;
        q.delete();
        for (c = 0; c < budget; c++) begin
            if (sent == nwords && q.size() == 0) break;
            @(negedge clk);
            i_wide_valid = (sent < nwords) &&
                           (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
            if (rnd) begin
                i_wide_data  = {$urandom, $urandom};
                i_lane_count = 3'($urandom_range(0, 7));
                i_data_ready = ($urandom_range(0, 3) != 0);
            end else begin
                for (int k = 0; k < 4; k++)
                    i_wide_data[k*16 +: 16] = {8'(sent), 8'(k)};
                i_lane_count = 3'd4;
                i_data_ready = 1'b1;
            end
            #1;
            chk("sb_valid", 64'(o_data_valid), 64'(q.size() > 0));
            if (o_data_valid && q.size() > 0) begin
                if (first < 0) first = c;
                lastc = c;
                chk("sb_data", 64'(o_data_out), 64'(q[0].d));
                chk("sb_last", 64'(o_last), 64'(q[0].l));
                if (i_data_ready) e = q.pop_front();
            end
            if (i_wide_valid && o_wide_ready) begin
                model_push(i_wide_data, i_lane_count);
                sent++;
            end
        end
        chk("sb_timeout", 64'(c < budget), 64'(1));
        if (!rnd) chk("stream_span", 64'(lastc - first + 1), 64'(32));
        @(negedge clk);
        idle();
        #1;
        chk("sb_drained", 64'(o_data_valid), 64'(0));
    endtask

    localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] WA = 64'h000d_000c_000b_000a;
    localparam logic [63:0] WB = 64'h0014_0013_0012_0011;
    localparam logic [63:0] WC = 64'h0ccc_0ccc_0ccc_0ccc;
    localparam logic [63:0] WD = 64'h0099_0099_0022_0021;
    localparam logic [63:0] WE = 64'h0034_0033_0032_0031;
    localparam logic [63:0] WF = 64'h0777_0777_0777_0041;
    localparam logic [63:0] WG = 64'h0777_0777_0777_0051;
    localparam logic [63:0] WH = 64'h0064_0063_0062_0061;
    localparam logic [63:0] WJ = 64'h0074_0073_0072_0071;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        idle();

        //       rst wv data lc dr chk ev exp_data last wrdy
        vt.push_back(mk(1, 0, 0,  0, 0, 0, 0, 16'h0,    0, 1));
        vt.push_back(mk(0, 1, W1, 4, 1, 1, 0, 16'h0,    0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h1111, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h2222, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h3333, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h4444, 1, 1));
        vt.push_back(mk(0, 1, WA, 4, 0, 1, 0, 16'h0,    0, 1));
        vt.push_back(mk(0, 1, WB, 4, 0, 1, 1, 16'h000a, 0, 1));
        vt.push_back(mk(0, 1, WC, 4, 0, 1, 1, 16'h000a, 0, 0));
        vt.push_back(mk(0, 1, WC, 4, 0, 1, 1, 16'h000a, 0, 0));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h000a, 0, 0));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h000b, 0, 0));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h000c, 0, 0));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h000d, 1, 0));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0011, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0012, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0013, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0014, 1, 1));
        vt.push_back(mk(0, 1, WD, 2, 1, 1, 0, 16'h0,    0, 1));
        vt.push_back(mk(0, 1, WE, 0, 1, 1, 1, 16'h0021, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0022, 1, 0));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0031, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0032, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0033, 0, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0034, 1, 1));
        vt.push_back(mk(0, 1, WF, 1, 1, 1, 0, 16'h0,    0, 1));
        vt.push_back(mk(0, 1, WG, 1, 1, 1, 1, 16'h0041, 1, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 1, 16'h0051, 1, 1));
        vt.push_back(mk(0, 0, 0,  0, 1, 1, 0, 16'h0,    0, 1));

        foreach (vt[i]) begin
            @(negedge clk);
            rst          = vt[i].rst;
            i_wide_valid = vt[i].wv;
            i_wide_data  = vt[i].wd;
            i_lane_count = vt[i].lc;
            i_data_ready = vt[i].dr;
            #1;
            if (vt[i].chk) begin
                chk($sformatf("v%0d_valid", i), 64'(o_data_valid), 64'(vt[i].ev));
                chk($sformatf("v%0d_wready", i), 64'(o_wide_ready), 64'(vt[i].ewr));
                chk($sformatf("v%0d_last", i), 64'(o_last), 64'(vt[i].el));
                if (vt[i].ev)
                    chk($sformatf("v%0d_data", i), 64'(o_data_out), 64'(vt[i].ed));
            end
        end

        // Reset in the middle of a word with a second word buffered.
        do_reset();
        @(negedge clk);
        i_wide_valid = 1'b1; i_wide_data = WH; i_lane_count = 3'd4;
        @(negedge clk);
        i_wide_data = WC;
        @(negedge clk);
        i_wide_valid = 1'b0;
        i_data_ready = 1'b1;
        #1;
        chk("mid_lane0", 64'(o_data_out), 64'h0061);
        @(negedge clk);
        #1;
        chk("mid_lane1", 64'(o_data_out), 64'h0062);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        i_data_ready = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(o_data_valid), 64'(0));
        chk("mid_rst_wready", 64'(o_wide_ready), 64'(1));
        i_wide_valid = 1'b1; i_wide_data = WJ; i_lane_count = 3'd4;
        @(negedge clk);
        idle();
        #1;
        chk("mid_new_valid", 64'(o_data_valid), 64'(1));
        chk("mid_new_lane0", 64'(o_data_out), 64'h0071);

        do_reset();
        run_sb(8, 1'b0, 200);

        do_reset();
        run_sb(1000, 1'b1, 40000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lake_deagg_buffer.md
LAKE_DEAGG_BUFFER -- requirements
Module: lake_deagg_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of one narrow output word.
REQ-002 SHALL have parameter FETCH_WIDTH, default 4, number of narrow lanes per wide input word (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_wide_data  input  FETCH_WIDTH*DATA_WIDTH  wide word; lane k is bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-006 SHALL have port i_wide_valid  input  1  wide word offered.
REQ-007 SHALL have port o_wide_ready  output  1  buffer can accept a wide word this cycle.
REQ-008 SHALL have port i_lane_count  input  clog2(FETCH_WIDTH)+1  number of lanes to emit from the word being pushed.
REQ-009 SHALL have port o_data_out  output  DATA_WIDTH  current narrow word.
REQ-010 SHALL have port o_data_valid  output  1  o_data_out holds a valid lane.
REQ-011 SHALL have port i_data_ready  input  1  downstream consumes o_data_out this cycle.
REQ-012 SHALL have port o_last  output  1  current lane is the final lane of its wide word.

Function
REQ-013 SHALL store up to two wide words in a ping-pong buffer (entries 0/1) with write pointer, read pointer, 2-bit occupancy (0..2) and lane counter.
REQ-014 SHALL drive o_wide_ready = (occupancy < 2), combinationally from registered state only (no dependency on i_data_ready).
REQ-015 SHALL push on i_wide_valid && o_wide_ready: write data and effective lane count into entry[wr_ptr], toggle wr_ptr.
REQ-016 SHALL compute effective lane count at push: i_lane_count if 1..FETCH_WIDTH, else FETCH_WIDTH (0 and overrange saturate).
REQ-017 SHALL drive o_data_valid = (occupancy > 0), o_data_out = lane[lane_cnt] of entry[rd_ptr], o_last = o_data_valid && (lane_cnt == stored count - 1).
REQ-018 SHALL pop a lane on o_data_valid && i_data_ready: if o_last, lane_cnt <= 0, toggle rd_ptr, release entry; else lane_cnt increments.
REQ-019 SHALL update occupancy: +1 on push only, -1 on last-lane pop only, unchanged on simultaneous push and last-lane pop.
REQ-020 SHALL present lane 0 of a word pushed into an empty buffer on the cycle after the push (latency 1); no combinational valid-to-valid path.
REQ-021 SHALL sustain one narrow word per cycle indefinitely when upstream always valid, downstream always ready, count = FETCH_WIDTH.
REQ-022 SHALL, with count = 1 and both sides continuously active, sustain one wide word per cycle (full state: push accepted in same cycle as release of the last entry is NOT permitted; ready is registered-state-based, giving one push per cycle at occupancy <=1).
REQ-023 SHALL hold o_data_out, o_last stable while o_data_valid && !i_data_ready.
REQ-024 SHALL ignore i_wide_data, i_lane_count when no push occurs.

Reset
REQ-025 SHALL, while rst is high at a clock edge, set occupancy=0, wr_ptr=0, rd_ptr=0, lane_cnt=0; outputs then o_data_valid=0, o_last=0, o_wide_ready=1.
REQ-026 SHALL discard buffered words and partially emitted words on reset mid-operation; no push or pop is recorded in a reset cycle.
REQ-027 SHALL not reset the data storage; o_data_out is don't-care while o_data_valid=0.

Structure
REQ-028 SHALL take DATA_WIDTH/FETCH_WIDTH defaults and the occupancy and lane-count typedefs from shared package lake_pkg.
REQ-029 SHALL be a single module; no sub-module instantiated.

Verification
REQ-030 Reset then push 0x4444_3333_2222_1111 (count=4), ready=1 -> 0x1111,0x2222,0x3333,0x4444 on cycles 1-4, o_last only on 0x4444.
REQ-031 Push two words back-to-back, i_data_ready=0 -> o_wide_ready=0 after second push, third offer stalled, o_data_out held at lane 0 of first word.
REQ-032 Push word with count=2 then count=0 -> first emits 2 lanes (o_last on lane 1), second emits 4 lanes.
REQ-033 Continuous valid/ready, count=4, 8 words -> 32 consecutive valid cycles, in-order data, occupancy never 0 after first output.
REQ-034 Assert rst after lane 1 of a word with a second word buffered -> next cycle o_data_valid=0, o_wide_ready=1; following push emits from lane 0.
REQ-035 Random valid/ready, random counts 0..7, 1000 words -> scoreboard match, no drop or duplicate.
